// File: rtl/sdram_burst_arbiter_if.sv
// Burst request handshake between the frame-buffer arbiter and the SDRAM core.
// The arbiter holds sd_req/sd_we/sd_addr until the core pulses sd_ack.
interface sdram_burst_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic              sd_req;
    logic              sd_we;
    logic [ADDR_W-1:0] sd_addr;
    logic              sd_ack;
    logic              sd_done;

    modport master (
        output sd_req,
        output sd_we,
        output sd_addr,
        input  sd_ack,
        input  sd_done
    );

    modport slave (
        input  sd_req,
        input  sd_we,
        input  sd_addr,
        output sd_ack,
        output sd_done
    );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Schedules fixed-length write/read SDRAM bursts from FIFO fill levels.
// Owns the write and read frame-buffer address counters.
module sdram_burst_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int FIFO_addr_size = 10,
    parameter int BURST_LEN      = 256,
    parameter int WR_BASE        = 0,
    parameter int RD_BASE        = 0,
    parameter int FRAME_WORDS    = 1024*768
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_done,
    input  logic [FIFO_addr_size-1:0] wf_rdusedw,
    input  logic [FIFO_addr_size-1:0] rf_wrusedw,
    input  logic                      rd_enable,
    input  logic                      wr_restart,
    input  logic                      rd_restart,
    sdram_burst_arbiter_if.master     sd,
    output logic                      busy,
    output logic                      wr_frame_done
);
    localparam int FW = FIFO_addr_size;

    localparam logic [FW:0]       BL_F      = (FW+1)'(BURST_LEN);
    localparam logic [FW:0]       FIFO_MAX  = (FW+1)'((2**FW) - 1);
    localparam logic [ADDR_W:0]   BL_A      = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0]   WR_END    = (ADDR_W+1)'(WR_BASE + FRAME_WORDS);
    localparam logic [ADDR_W:0]   RD_END    = (ADDR_W+1)'(RD_BASE + FRAME_WORDS);
    localparam logic [ADDR_W-1:0] WR_BASE_A = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RD_BASE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_REQ,
        S_BUSY
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              last_wr_q, last_wr_d;
    logic              fdone_q, fdone_d;

    logic [FW:0]       rd_free;
    logic              wr_ok;
    logic              rd_ok;
    logic              pick_wr;
    logic [ADDR_W:0]   wr_next;
    logic [ADDR_W:0]   rd_next;

    // Free space is computed one bit wider so a full FIFO never wraps.
    assign rd_free = FIFO_MAX - {1'b0, rf_wrusedw};
    assign wr_ok   = {1'b0, wf_rdusedw} >= BL_F;
    assign rd_ok   = rd_enable && (rd_free >= BL_F);
    assign pick_wr = wr_ok && !(rd_ok && last_wr_q);
    assign wr_next = {1'b0, wr_addr_q} + BL_A;
    assign rd_next = {1'b0, rd_addr_q} + BL_A;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_pend_d = wr_pend_q | wr_restart;
        rd_pend_d = rd_pend_q | rd_restart;
        last_wr_d = last_wr_q;
        fdone_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (init_done) state_d = S_ARB;
            end
            S_ARB: begin
                if (wr_pend_d) begin
                    wr_addr_d = WR_BASE_A;
                    wr_pend_d = 1'b0;
                end
                if (rd_pend_d) begin
                    rd_addr_d = RD_BASE_A;
                    rd_pend_d = 1'b0;
                end
                if (wr_ok || rd_ok) begin
                    req_d     = 1'b1;
                    we_d      = pick_wr;
                    addr_d    = pick_wr ? wr_addr_d : rd_addr_d;
                    last_wr_d = pick_wr;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (sd.sd_ack) begin
                    req_d   = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (sd.sd_done) begin
                    state_d = S_ARB;
                    // A pending restart overrides the post-burst increment.
                    if (we_q && !wr_pend_d) begin
                        if (wr_next >= WR_END) begin
                            wr_addr_d = WR_BASE_A;
                            fdone_d   = 1'b1;
                        end else begin
                            wr_addr_d = wr_next[ADDR_W-1:0];
                        end
                    end else if (!we_q && !rd_pend_d) begin
                        if (rd_next >= RD_END) begin
                            rd_addr_d = RD_BASE_A;
                        end else begin
                            rd_addr_d = rd_next[ADDR_W-1:0];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wr_addr_q <= WR_BASE_A;
            rd_addr_q <= RD_BASE_A;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            last_wr_q <= 1'b0;
            fdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            last_wr_q <= last_wr_d;
            fdone_q   <= fdone_d;
        end
    end

    assign sd.sd_req     = req_q;
    assign sd.sd_we      = we_q;
    assign sd.sd_addr    = addr_q;
    assign busy          = (state_q == S_REQ) || (state_q == S_BUSY);
    assign wr_frame_done = fdone_q;
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter with a burst-index reference model.
// The model is stepped on every rising edge and compared on every falling edge.
module tb_sdram_burst_arbiter;
    localparam int ADDR_W = 24;
    localparam int FW     = 10;
    localparam int BL     = 256;
    localparam int WB     = 0;
    localparam int RB     = 0;
    localparam int FWORDS = 1024;
    localparam int NB     = FWORDS / BL;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic [FW-1:0] wf;
    logic [FW-1:0] rf;
    logic          rd_enable;
    logic          wr_restart;
    logic          rd_restart;
    logic          busy;
    logic          wr_frame_done;

    sdram_burst_arbiter_if #(.ADDR_W(ADDR_W)) sd ();

    sdram_burst_arbiter #(
        .ADDR_W(ADDR_W),
        .FIFO_addr_size(FW),
        .BURST_LEN(BL),
        .WR_BASE(WB),
        .RD_BASE(RB),
        .FRAME_WORDS(FWORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .init_done(init_done),
        .wf_rdusedw(wf),
        .rf_wrusedw(rf),
        .rd_enable(rd_enable),
        .wr_restart(wr_restart),
        .rd_restart(rd_restart),
        .sd(sd),
        .busy(busy),
        .wr_frame_done(wr_frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 arbitrate, 2 request, 3 burst.
    int m_ph    = 0;
    int m_widx  = 0;
    int m_ridx  = 0;
    int m_addr  = 0;
    bit m_req   = 0;
    bit m_we    = 0;
    bit m_last  = 0;
    bit m_wp    = 0;
    bit m_rp    = 0;
    bit m_fd    = 0;
    bit m_wok;
    bit m_rok;

    always @(posedge clk) begin
        if (!rst) begin
            m_ph = 0; m_widx = 0; m_ridx = 0; m_addr = 0;
            m_req = 0; m_we = 0; m_last = 0;
            m_wp = 0; m_rp = 0; m_fd = 0;
        end else begin
            m_fd = 0;
            m_wp = m_wp | wr_restart;
            m_rp = m_rp | rd_restart;
            case (m_ph)
                0: if (init_done) m_ph = 1;
                1: begin
                    if (m_wp) begin m_widx = 0; m_wp = 0; end
                    if (m_rp) begin m_ridx = 0; m_rp = 0; end
                    m_wok = int'(wf) >= BL;
                    m_rok = rd_enable && (((1 << FW) - 1 - int'(rf)) >= BL);
                    if (m_wok || m_rok) begin
                        m_we   = (m_wok && m_rok) ? !m_last : m_wok;
                        m_addr = m_we ? WB + m_widx * BL : RB + m_ridx * BL;
                        m_last = m_we;
                        m_req  = 1;
                        m_ph   = 2;
                    end
                end
                2: if (sd.sd_ack) begin m_req = 0; m_ph = 3; end
                3: if (sd.sd_done) begin
                    m_ph = 1;
                    if (m_we && !m_wp) begin
                        m_widx = (m_widx + 1) % NB;
                        m_fd   = (m_widx == 0);
                    end else if (!m_we && !m_rp) begin
                        m_ridx = (m_ridx + 1) % NB;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cyc_sd_req", sd.sd_req, m_req);
        check("cyc_busy", busy, (m_ph == 2 || m_ph == 3));
        check("cyc_frame_done", wr_frame_done, m_fd);
        if (m_req) begin
            check("cyc_sd_we", sd.sd_we, m_we);
            check("cyc_sd_addr", sd.sd_addr, m_addr);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string nm, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (sd.sd_req === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no sd_req expected sd_req=1", nm);
        end
    endtask

    task automatic do_burst(input string nm, input bit e_we, input int e_addr,
                            input int ack_dly, input bit stray,
                            input bit rrst, output bit fd);
        bit ok;
        wait_req(nm, ok);
        check({nm, "_we"}, sd.sd_we, e_we);
        check({nm, "_addr"}, sd.sd_addr, e_addr);
        for (int i = 0; i < ack_dly; i++) begin
            sd.sd_done = stray && (i == 0);
            tick(1);
            check({nm, "_hold_req"}, sd.sd_req, 1);
            check({nm, "_hold_addr"}, sd.sd_addr, e_addr);
        end
        sd.sd_done = 0;
        sd.sd_ack  = 1;
        tick(1);
        sd.sd_ack  = 0;
        check({nm, "_busy"}, busy, 1);
        if (rrst) begin
            rd_restart = 1;
            tick(1);
            rd_restart = 0;
        end
        tick(1);
        sd.sd_done = 1;
        tick(1);
        fd = wr_frame_done;
        sd.sd_done = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    bit fd;
    bit ok;

    initial begin
        rst = 0; init_done = 0; wf = '0; rf = 10'd1023; rd_enable = 1;
        wr_restart = 0; rd_restart = 0; sd.sd_ack = 0; sd.sd_done = 0;
        tick(3);
        check("rst_req", sd.sd_req, 0);
        check("rst_we", sd.sd_we, 0);
        check("rst_addr", sd.sd_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_fd", wr_frame_done, 0);

        rst = 1; init_done = 1; wf = 10'd255;
        tick(6);
        check("t1_below_burst_no_req", sd.sd_req, 0);
        wf = 10'd256;
        do_burst("t1_w0", 1, 0, 0, 0, 0, fd);

        rf = '0; wf = 10'd1023;
        do_burst("t2_r0", 0, 0, 0, 0, 0, fd);
        do_burst("t2_w256", 1, 256, 0, 0, 0, fd);
        do_burst("t2_r256", 0, 256, 0, 0, 0, fd);
        do_burst("t2_w512", 1, 512, 0, 0, 0, fd);
        check("t2_no_wrap_pulse", fd, 0);

        rd_enable = 0;
        do_burst("t3_w768", 1, 768, 0, 0, 0, fd);
        check("t3_wrap_pulse", fd, 1);
        do_burst("t3_w_base", 1, 0, 0, 0, 0, fd);
        check("t3_single_pulse", fd, 0);

        wf = '0;
        tick(2);
        sd.sd_ack = 1; tick(1); sd.sd_ack = 0;
        sd.sd_done = 1; tick(1); sd.sd_done = 0;
        wr_restart = 1; tick(1); wr_restart = 0;
        tick(3);
        check("idle_stray_ack_no_req", sd.sd_req, 0);
        check("idle_not_busy", busy, 0);

        rd_enable = 1;
        do_burst("t4_r512", 0, 512, 5, 1, 0, fd);
        do_burst("t5_r768", 0, 768, 0, 0, 0, fd);
        check("t5_rd_wrap_no_pulse", fd, 0);
        do_burst("t5_r0", 0, 0, 1, 0, 1, fd);
        do_burst("t5_r_restart", 0, 0, 0, 0, 0, fd);

        rd_enable = 0; wf = 10'd1023;
        do_burst("t5_w_restart", 1, 0, 0, 0, 0, fd);

        wait_req("t6_w256", ok);
        check("t6_w256_addr", sd.sd_addr, 256);
        sd.sd_ack = 1; tick(1); sd.sd_ack = 0;
        tick(1);
        rst = 0;
        tick(1);
        check("t6_rst_req", sd.sd_req, 0);
        check("t6_rst_busy", busy, 0);
        rst = 1;
        do_burst("t6_w_base", 1, 0, 0, 0, 0, fd);
        do_burst("t6_w256_again", 1, 256, 0, 0, 0, fd);
        wf = '0;
        tick(20);
        check("t6_no_read_burst", sd.sd_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
